// File: rtl/pixel_bridge_pkg.sv
// ============================================================================
// Module  : pixel_bridge_pkg
// Brief   : Register map, bit indices and field widths for the pixel bridge.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pixel_bridge_pkg;

  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_STATUS    = 3'd1;
  localparam logic [2:0] ADDR_LEVELS    = 3'd2;
  localparam logic [2:0] ADDR_PIXEL_IN  = 3'd3;
  localparam logic [2:0] ADDR_PIXEL_OUT = 3'd4;
  localparam logic [2:0] ADDR_FRAME_LEN = 3'd5;
  localparam logic [2:0] ADDR_PERF_PIX  = 3'd6;
  localparam logic [2:0] ADDR_PERF_RES  = 3'd7;

  localparam int CTRL_SOFT_CLR = 0;
  localparam int CTRL_IRQ_EN   = 1;

  localparam int ST_IN_FULL   = 0;
  localparam int ST_IN_EMPTY  = 1;
  localparam int ST_OUT_FULL  = 2;
  localparam int ST_OUT_EMPTY = 3;
  localparam int ST_DONE      = 4;
  localparam int ST_IN_OVF    = 5;
  localparam int ST_OUT_UDF   = 6;

  localparam int LEVEL_W = 16;
  localparam int FRAME_W = 16;

  typedef struct packed {
    logic out_udf;
    logic in_ovf;
    logic done;
    logic out_empty;
    logic out_full;
    logic in_empty;
    logic in_full;
  } status_t;

endpackage

`default_nettype wire

// File: rtl/pixel_bridge_fifo.sv
// ============================================================================
// Module  : pixel_bridge_fifo
// Brief   : Synchronous show-ahead FIFO with flush and occupancy level.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pixel_bridge_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Flush wins over any beat in the same cycle; a full FIFO never accepts.
  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  assign full      = (r_count == LW'(DEPTH));
  assign empty     = (r_count == '0);
  assign level     = r_count;
  assign head_data = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/pcie_pixel_stream_bridge.sv
// ============================================================================
// Module  : pcie_pixel_stream_bridge
// Brief   : Avalon-MM CSR/FIFO bridge between the PCIe BAR and the conv core.
//           Optional stall counters at 6/7 built with PIXEL_BRIDGE_PERF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pcie_pixel_stream_bridge
  import pixel_bridge_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int IN_DEPTH  = 512,
  parameter int OUT_DEPTH = 512
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              irq,
  output logic [DATA_W-1:0] pix_out_data,
  output logic              pix_out_valid,
  input  logic              pix_out_ready,
  input  logic [DATA_W-1:0] res_in_data,
  input  logic              res_in_valid,
  output logic              res_in_ready
);

  localparam int IN_LW  = $clog2(IN_DEPTH) + 1;
  localparam int OUT_LW = $clog2(OUT_DEPTH) + 1;

  logic              w_in_full, w_in_empty, w_out_full, w_out_empty;
  logic [IN_LW-1:0]  w_in_level;
  logic [OUT_LW-1:0] w_out_level;
  logic [DATA_W-1:0] w_in_head, w_out_head;

  logic w_wr_ctrl, w_wr_status, w_wr_pixel, w_wr_flen, w_rd_pixel;
  logic w_soft_clr, w_in_pop, w_res_push, w_out_pop, w_frame_hit;
  logic w_unused;

  logic               r_irq_en, r_done, r_in_ovf, r_out_udf, r_irq;
  logic               r_ready_en;
  logic [FRAME_W-1:0] r_frame_len, r_frame_cnt, w_cnt_next;
  logic [31:0]        r_rd_data, w_rd_mux;
  logic               r_rd_valid;
  status_t            w_status;
  logic [31:0]        w_levels;

  assign w_wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
  assign w_wr_status = avs_write && (avs_address == ADDR_STATUS);
  assign w_wr_pixel  = avs_write && (avs_address == ADDR_PIXEL_IN);
  assign w_wr_flen   = avs_write && (avs_address == ADDR_FRAME_LEN);
  assign w_rd_pixel  = avs_read  && (avs_address == ADDR_PIXEL_OUT);
  assign w_soft_clr  = w_wr_ctrl && avs_writedata[CTRL_SOFT_CLR];

  assign w_in_pop   = pix_out_valid && pix_out_ready;
  assign w_res_push = res_in_valid && res_in_ready;
  assign w_out_pop  = w_rd_pixel && !w_out_empty;
  assign w_unused   = ^avs_writedata;

  pixel_bridge_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (w_soft_clr),
    .push      (w_wr_pixel),
    .push_data (avs_writedata[DATA_W-1:0]),
    .pop       (w_in_pop),
    .head_data (w_in_head),
    .full      (w_in_full),
    .empty     (w_in_empty),
    .level     (w_in_level)
  );

  pixel_bridge_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (w_soft_clr),
    .push      (w_res_push),
    .push_data (res_in_data),
    .pop       (w_out_pop),
    .head_data (w_out_head),
    .full      (w_out_full),
    .empty     (w_out_empty),
    .level     (w_out_level)
  );

  // Keeps res_in_ready low while reset is held, high once running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ready_en <= 1'b0;
    else          r_ready_en <= 1'b1;
  end

  assign pix_out_valid = !w_in_empty;
  assign pix_out_data  = w_in_empty ? '0 : w_in_head;
  assign res_in_ready  = r_ready_en && !w_out_full;

  assign w_cnt_next  = r_frame_cnt + 1'b1;
  assign w_frame_hit = (r_frame_len != '0) && (w_cnt_next == r_frame_len);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_en    <= 1'b0;
      r_frame_len <= '0;
      r_frame_cnt <= '0;
      r_done      <= 1'b0;
      r_in_ovf    <= 1'b0;
      r_out_udf   <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_irq <= r_irq_en && r_done;
      if (w_wr_ctrl) r_irq_en    <= avs_writedata[CTRL_IRQ_EN];
      if (w_wr_flen) r_frame_len <= avs_writedata[FRAME_W-1:0];
      if (w_soft_clr) begin
        r_frame_cnt <= '0;
        r_done      <= 1'b0;
        r_in_ovf    <= 1'b0;
        r_out_udf   <= 1'b0;
      end else begin
        if (w_wr_flen)       r_frame_cnt <= '0;
        else if (w_res_push) r_frame_cnt <= w_frame_hit ? '0 : w_cnt_next;

        // Flag sets take priority over a same-cycle W1C.
        if (w_res_push && !w_wr_flen && w_frame_hit)   r_done <= 1'b1;
        else if (w_wr_status && avs_writedata[ST_DONE]) r_done <= 1'b0;

        if (w_wr_pixel && w_in_full)                      r_in_ovf <= 1'b1;
        else if (w_wr_status && avs_writedata[ST_IN_OVF]) r_in_ovf <= 1'b0;

        if (w_rd_pixel && w_out_empty)                     r_out_udf <= 1'b1;
        else if (w_wr_status && avs_writedata[ST_OUT_UDF]) r_out_udf <= 1'b0;
      end
    end
  end

`ifdef PIXEL_BRIDGE_PERF_EN
  logic [31:0] r_perf_pix, r_perf_res;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_pix <= '0;
      r_perf_res <= '0;
    end else begin
      if (w_soft_clr || (avs_write && (avs_address == ADDR_PERF_PIX)))
        r_perf_pix <= '0;
      else if (pix_out_valid && !pix_out_ready && (r_perf_pix != '1))
        r_perf_pix <= r_perf_pix + 1'b1;
      if (w_soft_clr || (avs_write && (avs_address == ADDR_PERF_RES)))
        r_perf_res <= '0;
      else if (res_in_valid && !res_in_ready && (r_perf_res != '1))
        r_perf_res <= r_perf_res + 1'b1;
    end
  end
`endif

  always_comb begin
    w_status.out_udf   = r_out_udf;
    w_status.in_ovf    = r_in_ovf;
    w_status.done      = r_done;
    w_status.out_empty = w_out_empty;
    w_status.out_full  = w_out_full;
    w_status.in_empty  = w_in_empty;
    w_status.in_full   = w_in_full;
  end

  always_comb begin
    w_levels                       = '0;
    w_levels[IN_LW-1:0]            = w_in_level;
    w_levels[LEVEL_W+OUT_LW-1:LEVEL_W] = w_out_level;
  end

  always_comb begin
    w_rd_mux = '0;
    case (avs_address)
      ADDR_CTRL:      w_rd_mux[CTRL_IRQ_EN] = r_irq_en;
      ADDR_STATUS:    w_rd_mux[6:0] = w_status;
      ADDR_LEVELS:    w_rd_mux = w_levels;
      ADDR_PIXEL_OUT: if (!w_out_empty) w_rd_mux[DATA_W-1:0] = w_out_head;
      ADDR_FRAME_LEN: w_rd_mux[FRAME_W-1:0] = r_frame_len;
`ifdef PIXEL_BRIDGE_PERF_EN
      ADDR_PERF_PIX:  w_rd_mux = r_perf_pix;
      ADDR_PERF_RES:  w_rd_mux = r_perf_res;
`endif
      default:        w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= avs_read;
      r_rd_data  <= avs_read ? w_rd_mux : '0;
    end
  end

  assign avs_readdata      = r_rd_data;
  assign avs_readdatavalid = r_rd_valid;
  assign irq               = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_pcie_pixel_stream_bridge.sv
// ============================================================================
// Module  : tb_pcie_pixel_stream_bridge
// Brief   : Scoreboard bench for the PCIe pixel stream bridge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pcie_pixel_stream_bridge;

  localparam int DATA_W    = 16;
  localparam int IN_DEPTH  = 512;
  localparam int OUT_DEPTH = 512;

  localparam logic [2:0] A_CTRL = 3'd0, A_STATUS = 3'd1, A_LEVELS = 3'd2,
                         A_PIN = 3'd3, A_POUT = 3'd4, A_FLEN = 3'd5,
                         A_PERF_PIX = 3'd6, A_PERF_RES = 3'd7;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [2:0]        avs_address;
  logic              avs_write, avs_read;
  logic [31:0]       avs_writedata, avs_readdata;
  logic              avs_readdatavalid, irq;
  logic [DATA_W-1:0] pix_out_data, res_in_data, tb_res_data;
  logic              pix_out_valid, pix_out_ready, res_in_valid, res_in_ready;
  logic              loop_en, tb_pix_ready, tb_res_valid, pix_chk_en;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0]       rd_exp[$];
  string             rd_name[$];
  logic [DATA_W-1:0] pix_exp[$];

  always #5 clk = ~clk;

  // Behavioural conv core: result = pixel + 1 when looped back.
  assign pix_out_ready = loop_en ? res_in_ready : tb_pix_ready;
  assign res_in_valid  = loop_en ? pix_out_valid : tb_res_valid;
  assign res_in_data   = loop_en ? DATA_W'(pix_out_data + 1'b1) : tb_res_data;

  pcie_pixel_stream_bridge #(
    .DATA_W(DATA_W), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_read(avs_read), .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .irq(irq),
    .pix_out_data(pix_out_data), .pix_out_valid(pix_out_valid), .pix_out_ready(pix_out_ready),
    .res_in_data(res_in_data), .res_in_valid(res_in_valid), .res_in_ready(res_in_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitors: readdata and stream beats checked against queued expectations.
  always @(negedge clk) begin
    if (avs_readdatavalid) begin
      if (rd_exp.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_readdatavalid: got 0x%08h, expected no read", avs_readdata);
      end else begin
        check(rd_name.pop_front(), avs_readdata, rd_exp.pop_front());
      end
    end
    if (pix_chk_en && pix_out_valid && pix_out_ready) begin
      if (pix_exp.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_pixel_beat: got 0x%04h, expected no beat", pix_out_data);
      end else begin
        check("pixel_stream", 32'(pix_out_data), 32'(pix_exp.pop_front()));
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    avs_read = 1'b1; avs_address = a;
    rd_exp.push_back(e); rd_name.push_back(n);
    @(posedge clk); #1;
    avs_read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [DATA_W-1:0] d);
    tb_res_valid = 1'b1; tb_res_data = d;
    @(posedge clk); #1;
    tb_res_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; avs_address = '0; avs_write = 1'b0; avs_read = 1'b0;
    avs_writedata = '0; loop_en = 1'b0; tb_pix_ready = 1'b0; tb_res_valid = 1'b0;
    tb_res_data = '0; pix_chk_en = 1'b1;

    // Reset state
    #3;
    check("rst_readdata", avs_readdata, 32'h0);
    check("rst_rdvalid", 32'(avs_readdatavalid), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_pix_valid", 32'(pix_out_valid), 32'h0);
    check("rst_res_ready", 32'(res_in_ready), 32'h0);
    #19 reset_n = 1'b1;
    @(posedge clk); #1;
    idle(1);
    check("res_ready_after_rst", 32'(res_in_ready), 32'h1);
    rd(A_CTRL,   32'h0, "rst_ctrl");
    rd(A_STATUS, 32'h0A, "rst_status");
    rd(A_LEVELS, 32'h0, "rst_levels");
    rd(A_FLEN,   32'h0, "rst_frame_len");
    rd(3'd6,     32'h0, "rst_addr6");

    // Basic loopback path
    wr(A_FLEN, 32'd4);
    wr(A_CTRL, 32'h2);
    loop_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix_exp.push_back(DATA_W'(16'h0011 + i));
      wr(A_PIN, 32'h0011 + i);
    end
    idle(6);
    loop_en = 1'b0;
    check("basic_irq_set", 32'(irq), 32'h1);
    rd(A_STATUS, 32'h12, "basic_status_done");
    rd(A_LEVELS, 32'h0004_0000, "basic_levels");
    for (int i = 0; i < 4; i++) rd(A_POUT, 32'h12 + i, "basic_pixel_out");
    rd(A_STATUS, 32'h1A, "basic_status_drained");
    wr(A_STATUS, 32'h10);
    idle(1);
    check("basic_irq_cleared", 32'(irq), 32'h0);
    rd(A_STATUS, 32'h0A, "basic_status_w1c");

    // Backpressure
    tb_pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pix_exp.push_back(DATA_W'(16'h00A1 + i));
      wr(A_PIN, 32'h00A1 + i);
    end
    rd(A_LEVELS, 32'h3, "bp_levels");
    check("bp_head", 32'(pix_out_data), 32'h00A1);
    idle(3);
    check("bp_head_stable", 32'(pix_out_data), 32'h00A1);
    tb_pix_ready = 1'b1;
    idle(5);
    tb_pix_ready = 1'b0;
    check("bp_all_popped", pix_exp.size(), 32'h0);

    // Input overflow
    for (int i = 0; i < IN_DEPTH + 2; i++) begin
      if (i < IN_DEPTH) pix_exp.push_back(DATA_W'(16'h1000 + i));
      wr(A_PIN, 32'h1000 + i);
    end
    rd(A_LEVELS, 32'(IN_DEPTH), "ovf_levels");
    rd(A_STATUS, 32'h29, "ovf_status");
    tb_pix_ready = 1'b1;
    idle(IN_DEPTH + 8);
    tb_pix_ready = 1'b0;
    check("ovf_all_popped", pix_exp.size(), 32'h0);
    wr(A_STATUS, 32'h20);
    rd(A_STATUS, 32'h0A, "ovf_status_w1c");

    // Output full and underflow
    wr(A_FLEN, 32'd0);
    for (int i = 0; i < OUT_DEPTH; i++) feed(DATA_W'(16'h2000 + i));
    check("outfull_res_ready", 32'(res_in_ready), 32'h0);
    feed(16'hDEAD);
    feed(16'hBEEF);
    rd(A_LEVELS, 32'(OUT_DEPTH) << 16, "outfull_levels");
    rd(A_STATUS, 32'h06, "outfull_status");
    for (int i = 0; i < OUT_DEPTH; i++) rd(A_POUT, 32'h2000 + i, "outfull_drain");
    rd(A_POUT, 32'h0, "udf_readdata");
    rd(A_STATUS, 32'h4A, "udf_status");
    wr(A_STATUS, 32'h40);
    rd(A_STATUS, 32'h0A, "udf_status_w1c");

    // Soft clear mid-frame
    wr(A_FLEN, 32'd3);
    feed(16'h3000);
    feed(16'h3001);
    for (int i = 0; i < 5; i++) wr(A_PIN, 32'h0050 + i);
    rd(A_LEVELS, 32'h0002_0005, "sclr_levels_before");
    wr(A_CTRL, 32'h1);
    rd(A_LEVELS, 32'h0, "sclr_levels_after");
    rd(A_STATUS, 32'h0A, "sclr_status");
    rd(A_CTRL, 32'h0, "sclr_ctrl_readback");
    check("sclr_pix_valid", 32'(pix_out_valid), 32'h0);
    feed(16'h3100);
    feed(16'h3101);
    rd(A_STATUS, 32'h02, "sclr_no_early_done");
    feed(16'h3102);
    rd(A_STATUS, 32'h12, "sclr_done_after_len");
    for (int i = 0; i < 3; i++) rd(A_POUT, 32'h3100 + i, "sclr_pixel_out");
    wr(A_STATUS, 32'h10);

    // Asynchronous reset during streaming
    wr(A_FLEN, 32'd1);
    wr(A_CTRL, 32'h2);
    wr(A_PIN, 32'h0055);
    wr(A_PIN, 32'h0066);
    feed(16'h0077);
    idle(2);
    check("pre_arst_irq", 32'(irq), 32'h1);
    check("pre_arst_pix_data", 32'(pix_out_data), 32'h0055);
    #3 reset_n = 1'b0;
    #1;
    check("arst_irq", 32'(irq), 32'h0);
    check("arst_pix_valid", 32'(pix_out_valid), 32'h0);
    check("arst_pix_data", 32'(pix_out_data), 32'h0);
    check("arst_res_ready", 32'(res_in_ready), 32'h0);
    check("arst_readdata", avs_readdata, 32'h0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;
    idle(1);
    rd(A_PERF_PIX, 32'h0, "arst_perf_pix");
    rd(A_PERF_RES, 32'h0, "arst_perf_res");
    rd(A_LEVELS,   32'h0, "arst_levels");
    rd(A_STATUS,   32'h0A, "arst_status");
    rd(A_CTRL,     32'h0, "arst_ctrl");
    rd(A_FLEN,     32'h0, "arst_frame_len");

    idle(4);
    check("reads_outstanding", rd_exp.size(), 32'h0);
    check("pixels_outstanding", pix_exp.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
